mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller for the execute stage.
- Accepts one M-extension operation from execute, sequences a 3-cycle multiplier or a radix-2 restoring divider, and drives the execute-stage stall (`alustall`) until the result is ready.
- Holds the result while the pipeline is externally stalled. Aborts on flush.

Parameters:
- XLEN, 64, datapath width.
- MUL_LAT, 3, cycles from accept to result for MUL/MULW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: state clears on a rising edge where reset==0.
- start  in  1  execute stage holds a valid M-op. Stays high for as long as the instruction sits in execute.
- op  in  3  000 MUL, 001 DIV, 010 DIVU, 011 REM, 100 REMU; other codes are treated as MUL.
- w  in  1  32-bit (W) variant.
- a  in  XLEN  operand rs1 (already forwarded).
- b  in  XLEN  operand rs2 (already forwarded).
- stallE  in  1  execute stage held by another stall source.
- flush  in  1  kill the in-flight operation.
- result  out  XLEN  operation result; valid when done==1.
- done  out  1  result valid this cycle.
- alustall  out  1  execute must stall this cycle.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset values:
  - state=IDLE.
  - result=0, done=0, alustall=0.
  - Iteration counter, quotient and remainder registers = 0.
- Reset mid-operation: the operation is dropped and nothing is reported.
- alustall = (state==IDLE && start && !flush) || state==MUL || state==DIV.
- done = (state==DONE).
- alustall and done are never both high in one cycle.
- Accept (cycle 0): in IDLE with start=1 and flush=0, latch the operands, op and w.
- W operand preparation:
  - Signed ops: sign-extend a[31:0] and b[31:0].
  - Unsigned ops: zero-extend a[31:0] and b[31:0].
- Division fast path, checked on the prepared operands in cycle 0. Next state is DONE in cycle 1.
  - Divide by zero (b==0): DIV/DIVU result = all ones; REM/REMU result = dividend.
  - Signed overflow (DIV/REM, dividend = most-negative value of the active width, divisor = -1): DIV result = dividend; REM result = 0.
- MUL path:
  - Low XLEN bits of a*b are taken from a pipelined product.
  - State is MUL for cycles 1..MUL_LAT-1; DONE in cycle MUL_LAT.
- DIV path:
  - Operands are converted to magnitudes for signed ops.
  - One restoring iteration per cycle: N=64 for 64-bit ops, N=32 for W ops.
  - The counter runs 0..N-1 during cycles 1..N; sign fix-up is applied on the last iteration.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - DONE in cycle N+1: 64-bit ops in cycle 65, W ops in cycle 33.
- W results: sign-extend bit 31 of the 32-bit result to 64 bits, for all ops including unsigned.
- DONE state:
  - result is held stable.
  - Stays in DONE while stallE==1.
  - Goes to IDLE on the first cycle with stallE==0; the instruction advances on that edge.
  - Exception: a start seen in IDLE on the very next cycle is a new instruction and is accepted.
- flush:
  - Any state with flush==1 → IDLE next cycle; done=0 and alustall=0 from then on.
  - flush and start in the same cycle: flush wins and nothing is accepted.
- No new accept is possible outside IDLE; operand changes during MUL/DIV/DONE are ignored.

Test Plan:
- MUL: a=3, b=-5 (0xFFFF_FFFF_FFFF_FFFB), start held → alustall high cycles 0-2, done in cycle 3 with result 0xFFFF_FFFF_FFFF_FFF1.
- DIVU: a=100, b=7 → alustall high cycles 0-64, cycle 65 result=14; repeat with REMU → 2.
- REMW: a=0x0000_0000_FFFF_FFF9 (-7 in 32 bits), b=2 → cycle 33 result 0xFFFF_FFFF_FFFF_FFFF. DIVW with the same operands → 0xFFFF_FFFF_FFFF_FFFD.
- Fast path:
  - DIV a=5, b=0 → alustall only in cycle 0, cycle 1 result all ones.
  - REM a=5, b=0 → 5.
  - DIV a=0x8000_0000_0000_0000, b=-1 → cycle 1 result 0x8000_0000_0000_0000; REM → 0.
- Hold: stallE=1 for 4 cycles upon reaching DONE → result/done stable across those cycles; returns to IDLE after the first cycle with stallE=0.
- Abort: flush in cycle 20 of a DIV → IDLE next cycle, alustall=0, done never asserted. reset=0 in cycle 10 of a DIV → all outputs 0 after the edge. A subsequent DIVU 100/7 completes correctly with result 14.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer bus: M-op request, operands,
// pipeline control and the result/stall response.
interface mdu_sequencer_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [2:0]      op;
    logic            w;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            stallE;
    logic            flush;
    logic [XLEN-1:0] result;
    logic            done;
    logic            alustall;

    modport master (
        output start, op, w, a, b, stallE, flush,
        input  result, done, alustall
    );

    modport slave (
        input  start, op, w, a, b, stallE, flush,
        output result, done, alustall
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle M-extension controller: pipelined multiplier, radix-2 restoring
// divider with zero/overflow fast path, and execute-stage stall generation.
module mdu_sequencer #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3
) (
    input logic           clk,
    input logic           reset,
    mdu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [6:0]      r_cnt;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_prod;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_w;
    logic            r_is_rem;
    logic [XLEN-1:0] r_result;
    logic            r_done;

    logic            w_signed;
    logic            w_is_rem;
    logic            w_is_div;
    logic [XLEN-1:0] w_a_prep;
    logic [XLEN-1:0] w_b_prep;
    logic [XLEN-1:0] w_min;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN:0]   w_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [6:0]      w_last;
    logic            w_alustall;

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic is_w);
        if (is_w) begin
            wext = {{(XLEN-32){v[31]}}, v[31:0]};
        end else begin
            wext = v;
        end
    endfunction

    // Decode the op and prepare operands / fast-path result for the accept cycle
    always_comb begin
        w_signed = (bus.op == 3'd1) || (bus.op == 3'd3);
        w_is_rem = (bus.op == 3'd3) || (bus.op == 3'd4);
        w_is_div = (bus.op >= 3'd1) && (bus.op <= 3'd4);
        if (bus.w && w_signed) begin
            w_a_prep = {{(XLEN-32){bus.a[31]}}, bus.a[31:0]};
            w_b_prep = {{(XLEN-32){bus.b[31]}}, bus.b[31:0]};
        end else if (bus.w) begin
            w_a_prep = {{(XLEN-32){1'b0}}, bus.a[31:0]};
            w_b_prep = {{(XLEN-32){1'b0}}, bus.b[31:0]};
        end else begin
            w_a_prep = bus.a;
            w_b_prep = bus.b;
        end
        // most-negative value of the active width, as seen after sign extension
        if (bus.w) begin
            w_min = {{(XLEN-31){1'b1}}, 31'd0};
        end else begin
            w_min = {1'b1, {(XLEN-1){1'b0}}};
        end
        w_fast_res = {XLEN{1'b1}};
        if (w_b_prep == {XLEN{1'b0}}) begin
            w_fast     = 1'b1;
            w_fast_res = w_is_rem ? w_a_prep : {XLEN{1'b1}};
        end else if (w_signed && (w_a_prep == w_min) && (w_b_prep == {XLEN{1'b1}})) begin
            w_fast     = 1'b1;
            w_fast_res = w_is_rem ? {XLEN{1'b0}} : w_a_prep;
        end else begin
            w_fast     = 1'b0;
        end
        w_mag_a = (w_signed && w_a_prep[XLEN-1]) ? -w_a_prep : w_a_prep;
        w_mag_b = (w_signed && w_b_prep[XLEN-1]) ? -w_b_prep : w_b_prep;
    end

    // One restoring-division step plus sign fix-up of its outcome
    always_comb begin
        w_sh     = {r_rem, r_quo[XLEN-1]};
        w_ge     = (w_sh >= {1'b0, r_div});
        w_diff   = w_sh[XLEN-1:0] - r_div;
        w_rem_nx = w_ge ? w_diff : w_sh[XLEN-1:0];
        w_quo_nx = {r_quo[XLEN-2:0], w_ge};
        w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
        w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;
        w_last   = r_w ? 7'd31 : 7'd63;
    end

    // Stall is combinational: the accept cycle itself must already stall execute
    always_comb begin
        w_alustall = 1'b0;
        case (r_state)
            S_IDLE:  w_alustall = bus.start && !bus.flush;
            S_MUL:   w_alustall = 1'b1;
            S_DIV:   w_alustall = 1'b1;
            default: w_alustall = 1'b0;
        endcase
    end

    // Sequencer FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 7'd0;
            r_a      <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
            r_prod   <= {XLEN{1'b0}};
            r_quo    <= {XLEN{1'b0}};
            r_rem    <= {XLEN{1'b0}};
            r_div    <= {XLEN{1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_w      <= 1'b0;
            r_is_rem <= 1'b0;
            r_result <= {XLEN{1'b0}};
            r_done   <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_w      <= bus.w;
                        r_is_rem <= w_is_rem;
                        r_cnt    <= 7'd0;
                        if (!w_is_div) begin
                            r_a     <= bus.a;
                            r_b     <= bus.b;
                            r_state <= S_MUL;
                        end else if (w_fast) begin
                            r_result <= wext(w_fast_res, bus.w);
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            // W dividends sit in the top half so N=32 shifts consume them
                            r_quo   <= bus.w ? {w_mag_a[31:0], 32'd0} : w_mag_a;
                            r_rem   <= {XLEN{1'b0}};
                            r_div   <= w_mag_b;
                            r_neg_q <= w_signed && (w_a_prep[XLEN-1] ^ w_b_prep[XLEN-1]);
                            r_neg_r <= w_signed && w_a_prep[XLEN-1];
                            r_state <= S_DIV;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_prod <= r_a * r_b;
                    if (r_cnt == 7'(MUL_LAT - 2)) begin
                        r_result <= wext(r_prod, r_w);
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_DIV: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == w_last) begin
                        r_result <= wext(r_is_rem ? w_r_fix : w_q_fix, r_w);
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_DONE: begin
                    if (!bus.stallE) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result   = r_result;
    assign bus.done     = r_done;
    assign bus.alustall = w_alustall;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: vector table of M-ops with hand-computed
// results and latencies, plus hold, back-to-back, flush and reset sequences.
module tb_mdu_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mdu_sequencer_if #(.XLEN(64)) bus();

    mdu_sequencer #(.XLEN(64), .MUL_LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one op at the start of a cycle; done expected exactly lat cycles later
    task automatic run_vec(input vec_t v, input string name);
        bit stall_ok;
        stall_ok  = 1'b1;
        bus.op    = v.op;
        bus.w     = v.w;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.start = 1'b1;
        for (int k = 0; k <= v.lat; k++) begin
            @(negedge clk);
            if (k < v.lat) begin
                if (!(bus.alustall === 1'b1 && bus.done === 1'b0)) stall_ok = 1'b0;
            end else begin
                chk({name, " done"}, 64'(bus.done), 64'd1);
                chk({name, " result"}, bus.result, v.exp);
                chk({name, " alustall_at_done"}, 64'(bus.alustall), 64'd0);
            end
            next_cycle();
        end
        chk({name, " stall_window"}, 64'(stall_ok), 64'd1);
        bus.start = 1'b0;
        @(negedge clk);
        chk({name, " retire"}, {62'd0, bus.done, bus.alustall}, 64'd0);
        next_cycle();
    endtask

    initial begin
        bit ok;
        vec_t v;
        checks   = 0;
        failures = 0;
        vecs[0]  = '{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 3};
        vecs[1]  = '{3'd2, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        vecs[2]  = '{3'd4, 1'b0, 64'd100, 64'd7, 64'd2, 65};
        vecs[3]  = '{3'd3, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[4]  = '{3'd1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[5]  = '{3'd1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[6]  = '{3'd3, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        vecs[7]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[8]  = '{3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[9]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
        vecs[10] = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[11] = '{3'd0, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 3};
        vecs[12] = '{3'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33};
        vecs[13] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[14] = '{3'd1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[15] = '{3'd7, 1'b0, 64'd6, 64'd7, 64'd42, 3};

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.w      = 1'b0;
        bus.a      = 64'd0;
        bus.b      = 64'd0;
        bus.stallE = 1'b0;
        bus.flush  = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("reset_outputs", {bus.result[61:0], bus.done, bus.alustall}, 64'd0);
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Hold: MUL 6*7 reaches DONE in cycle 3, stallE high cycles 3..6
        bus.op = 3'd0; bus.w = 1'b0; bus.a = 64'd6; bus.b = 64'd7; bus.start = 1'b1;
        next_cycle();
        next_cycle();
        bus.stallE = 1'b1;
        next_cycle();
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!(bus.done === 1'b1 && bus.alustall === 1'b0 && bus.result === 64'd42)) ok = 1'b0;
            next_cycle();
        end
        chk("hold_stable", 64'(ok), 64'd1);
        bus.stallE = 1'b0;
        @(negedge clk);
        chk("hold_release_done", 64'(bus.done), 64'd1);
        chk("hold_release_result", bus.result, 64'd42);
        next_cycle();
        // Back-to-back: a new instruction in the very next cycle is accepted
        v = '{3'd0, 1'b0, 64'd16, 64'd16, 64'd256, 3};
        run_vec(v, "back_to_back");

        // Flush in cycle 20 of a DIVU
        bus.op = 3'd2; bus.w = 1'b0; bus.a = 64'd100; bus.b = 64'd7; bus.start = 1'b1;
        repeat (20) next_cycle();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("flush_idle", {62'd0, bus.done, bus.alustall}, 64'd0);
        ok = 1'b1;
        for (int k = 0; k < 70; k++) begin
            next_cycle();
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.alustall !== 1'b0) ok = 1'b0;
        end
        chk("flush_no_done", 64'(ok), 64'd1);
        next_cycle();

        // flush together with start in IDLE: nothing accepted
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_start_stall", 64'(bus.alustall), 64'd0);
        next_cycle();
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_start_not_accepted", {62'd0, bus.done, bus.alustall}, 64'd0);
        next_cycle();

        // Reset in cycle 10 of a DIVU, then a clean DIVU
        bus.start = 1'b1;
        repeat (10) next_cycle();
        reset = 1'b0;
        next_cycle();
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midop_reset", {bus.result[61:0], bus.done, bus.alustall}, 64'd0);
        next_cycle();
        v = '{3'd2, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        run_vec(v, "after_reset_divu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
